data_memory_param: RTL and testbench
====================================

Name: data_memory_param

Overview:
Parametrised single-port synchronous data memory for the datapath load/store stage. It generalises the 8-bit data memory:
- configurable width and depth
- per-byte write enables
- registered reads with a valid strobe
- write-first read-during-write
- out-of-range address detection
- hardware clear sequencer that zeroes the array after reset or on request

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address bus width.
DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.

Ports:
clock  input  1  rising-edge clock; all state changes on this edge except reset.
reset_n  input  1  asynchronous active-low reset.
signal_memread  input  1  read request, sampled on clock edge.
signal_memwrite  input  1  write request, sampled on clock edge.
address  input  ADDR_WIDTH  word address.
data_to_write  input  DATA_WIDTH  write data.
byte_enable  input  DATA_WIDTH/8  bit i enables write of byte i (bits 8i+7:8i).
signal_clear  input  1  request full-array zeroing; honoured in IDLE only.
data_out  output  DATA_WIDTH  registered read data.
data_valid  output  1  one-cycle strobe: data_out updated this cycle.
addr_error  output  1  one-cycle strobe: the accepted access had address >= DEPTH.
signal_busy  output  1  high while clear sequencer runs; accesses are dropped.

Behaviour:
- Reset (reset_n low, asynchronous):
  - data_out=0, data_valid=0, addr_error=0.
  - signal_busy=1, state=CLEAR, clear counter=0.
  - The array itself has no reset; the sequencer zeroes it.
- FSM, two states:
  - CLEAR: each cycle write 0 to mem[counter], counter++. After writing DEPTH-1, go to IDLE next edge. signal_busy drops in the same cycle IDLE is entered. Clear lasts exactly DEPTH cycles after reset release.
  - IDLE: serve accesses. signal_clear=1 on an edge moves to CLEAR with counter=0. An access presented on that same edge is dropped. signal_busy=1 from the next cycle.
- In CLEAR:
  - signal_memread and signal_memwrite are ignored; no memory change.
  - data_valid=0, addr_error=0; data_out holds.
  - signal_clear is ignored (no restart).
- Write in IDLE (signal_memwrite=1, address<DEPTH):
  - Only bytes with byte_enable[i]=1 are updated; other bytes are preserved.
  - byte_enable all-zero means no change.
- Read in IDLE (signal_memread=1, address<DEPTH): data_out=mem[address] and data_valid=1 on the next edge. Latency is 1 cycle.
- Read and write together, same cycle (same address by definition):
  - Write-first: data_out is the merged post-write word.
  - Enabled bytes come from data_to_write; others from the old word.
- No read that cycle: data_valid=0; data_out holds its previous value.
- Out of range (address>=DEPTH, with read or write asserted):
  - Write is discarded; array unchanged.
  - A read returns data_out=0 with data_valid=1.
  - addr_error=1 for one cycle, aligned with the data_valid timing.
  - Never aliases or wraps.
- Reset mid-clear or mid-access: reset takes effect immediately. Clear restarts from address 0 after reset release.
- Back-to-back accesses every cycle are supported with no bubbles.

Test Plan:
1. Release reset with DEPTH=256 -> signal_busy=1 for exactly 256 cycles, then 0. Reads of addresses 0, 128, 255 return 0 with data_valid=1 one cycle after each request.
2. Defaults: write addr 0x00 data 0x0F, be=1, then read addr 0x00 -> next cycle data_out=0x0F, data_valid=1. The following idle cycle gives data_valid=0 with data_out still 0x0F.
3. DATA_WIDTH=32: write addr 5 data 0xAABBCCDD be=4'b1111, then write 0x11223344 be=4'b0101, then read addr 5 -> 0xAA22CC44.
4. DATA_WIDTH=32, word 0x00000000: read and write addr 7 in the same cycle, data 0xDEADBEEF, be=4'b0011 -> data_out=0x0000BEEF next cycle. A later read returns the same value.
5. DEPTH=200, ADDR_WIDTH=8: write addr 210 data 0x55, then read 210 and read 210-128=82 -> addr_error=1 on the first two accesses. Read of 210 returns 0; read of 82 returns 0 (no aliasing).
6. After writing 0x3C to addr 3, pulse signal_clear while also requesting read addr 3 -> read dropped (data_valid=0), signal_busy=1 for 256 cycles. Afterwards read addr 3 returns 0x00. Asserting reset_n low mid-clear forces data_out=0 and data_valid=0 immediately, and clear restarts from 0.

Source files
------------

// File: rtl/data_memory_param.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_param
//  Purpose  : Parametrised single-port synchronous data memory for the
//             load/store stage. Per-byte write enables, registered reads
//             with a valid strobe, write-first read-during-write,
//             out-of-range address detection, and a hardware clear
//             sequencer that zeroes the whole array after reset or on
//             request.
//
//  Ports    :
//    clock           in   rising-edge clock
//    reset_n         in   asynchronous active-low reset
//    signal_memread  in   read request (sampled on clock edge)
//    signal_memwrite in   write request (sampled on clock edge)
//    address         in   word address [ADDR_WIDTH]
//    data_to_write   in   write data [DATA_WIDTH]
//    byte_enable     in   per-byte write enable [DATA_WIDTH/8]
//    signal_clear    in   request full-array zeroing (honoured in IDLE)
//    data_out        out  registered read data [DATA_WIDTH]
//    data_valid      out  one-cycle strobe: data_out updated
//    addr_error      out  one-cycle strobe: accepted access was out of range
//    signal_busy     out  clear sequencer running; accesses are dropped
//
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    signal_memread,
    input  logic                    signal_memwrite,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_to_write,
    input  logic [DATA_WIDTH/8-1:0] byte_enable,
    input  logic                    signal_clear,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    addr_error,
    output logic                    signal_busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_num_bytes = DATA_WIDTH / 8;
    // Index width sized to the array so no address bit is ever folded
    // onto a real word; range is checked against the full address.
    localparam int c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(DEPTH - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_idx_w-1:0]     r_clr_cnt;
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic                   r_data_valid;
    logic                   r_addr_error;
    logic                   r_busy;

    // ------------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------------
    logic                   w_in_range;
    logic [c_idx_w-1:0]     w_idx;
    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_any_req;
    logic                   w_clear_wr;
    logic                   w_clear_last;
    logic [DATA_WIDTH-1:0]  w_old_word;
    logic [DATA_WIDTH-1:0]  w_merged_word;

    // Zero-extend the address by one bit so DEPTH == 2**ADDR_WIDTH still
    // compares correctly.
    assign w_in_range   = ({1'b0, address} < c_depth);
    assign w_idx        = address[c_idx_w-1:0];

    // A clear request on the same edge wins over any access presented with it.
    assign w_accept     = (r_state == ST_IDLE) && !signal_clear;
    assign w_wr_en      = w_accept && signal_memwrite && w_in_range;
    assign w_rd_en      = w_accept && signal_memread;
    assign w_any_req    = signal_memread || signal_memwrite;

    assign w_clear_wr   = (r_state == ST_CLEAR);
    assign w_clear_last = (r_clr_cnt == c_last_idx);

    // ------------------------------------------------------------------------
    // Storage: one byte-wide array per lane so each lane has its own write
    // enable and no array is written from more than one process.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < c_num_bytes; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];

        always_ff @(posedge clock) begin
            if (w_clear_wr) begin
                r_mem[r_clr_cnt] <= 8'h00;
            end else if (w_wr_en && byte_enable[gi]) begin
                r_mem[w_idx] <= data_to_write[8*gi +: 8];
            end
        end

        // Old contents of the addressed word; only consumed when in range.
        assign w_old_word[8*gi +: 8] = r_mem[w_idx];

        // Write-first view of the word: enabled lanes take the incoming data.
        assign w_merged_word[8*gi +: 8] =
            (signal_memwrite && byte_enable[gi]) ? data_to_write[8*gi +: 8]
                                                 : w_old_word[8*gi +: 8];
    end

    // ------------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_busy       <= 1'b1;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // Accesses and clear requests are ignored; data_out holds.
                    r_data_valid <= 1'b0;
                    r_addr_error <= 1'b0;
                    if (w_clear_last) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (signal_clear) begin
                        r_state      <= ST_CLEAR;
                        r_clr_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_data_valid <= 1'b0;
                        r_addr_error <= 1'b0;
                    end else begin
                        r_data_valid <= w_rd_en;
                        r_addr_error <= w_any_req && !w_in_range;
                        if (w_rd_en) begin
                            // Out-of-range reads return zero rather than any
                            // aliased word.
                            r_data_out <= w_in_range ? w_merged_word : '0;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign addr_error  = r_addr_error;
    assign signal_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_param
//  Purpose  : Self-checking bench for data_memory_param. Instance A uses the
//             default 8-bit / 256-word configuration; instance B uses
//             32-bit words, 8-bit address and 200 words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_memory_param;

    logic clock;
    logic reset_n;

    // Instance A: 8-bit data, 256 words
    logic        rd_a, wr_a, clr_a;
    logic [7:0]  addr_a, din_a, dout_a;
    logic [0:0]  be_a;
    logic        valid_a, err_a, busy_a;

    // Instance B: 32-bit data, 200 words
    logic        rd_b, wr_b, clr_b;
    logic [7:0]  addr_b;
    logic [31:0] din_b, dout_b;
    logic [3:0]  be_b;
    logic        valid_b, err_b, busy_b;

    int n_checks;
    int n_errors;

    data_memory_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) dut_a (
        .clock           (clock),
        .reset_n         (reset_n),
        .signal_memread  (rd_a),
        .signal_memwrite (wr_a),
        .address         (addr_a),
        .data_to_write   (din_a),
        .byte_enable     (be_a),
        .signal_clear    (clr_a),
        .data_out        (dout_a),
        .data_valid      (valid_a),
        .addr_error      (err_a),
        .signal_busy     (busy_a)
    );

    data_memory_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200)) dut_b (
        .clock           (clock),
        .reset_n         (reset_n),
        .signal_memread  (rd_b),
        .signal_memwrite (wr_b),
        .address         (addr_b),
        .data_to_write   (din_b),
        .byte_enable     (be_b),
        .signal_clear    (clr_b),
        .data_out        (dout_b),
        .data_valid      (valid_b),
        .addr_error      (err_b),
        .signal_busy     (busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sel_b;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        rd_a = 0; wr_a = 0; clr_a = 0; addr_a = 0; din_a = 0; be_a = 0;
        rd_b = 0; wr_b = 0; clr_b = 0; addr_b = 0; din_b = 0; be_b = 0;
    endtask

    // Counts negedges on which each busy flag is high, stopping once both
    // are low; also records whether any valid strobe appeared while busy.
    task automatic count_busy(output int na, output int nb, output logic saw_valid);
        na = 0; nb = 0; saw_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) begin
                na++;
                if (valid_a) saw_valid = 1'b1;
            end
            if (busy_b) nb++;
            @(negedge clock);
        end
    endtask

    // One access on instance A, outputs sampled at the following negedge.
    task automatic op_a(input logic rd, input logic wr, input logic clr,
                        input logic [7:0] addr, input logic [7:0] din, input logic be);
        rd_a = rd; wr_a = wr; clr_a = clr; addr_a = addr; din_a = din; be_a = be;
        @(negedge clock);
        idle_all();
    endtask

    int   cnt_a, cnt_b;
    logic saw_v;

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_all();
        reset_n = 1'b0;

        // ---------------- table: reads/writes after initial clear ----------
        //              sel rd wr addr   data          be    v  exp_data      err
        vecs[0]  = '{1'b0,1,0,8'h00,32'h0,        4'h0, 1,32'h00,       0};
        vecs[1]  = '{1'b0,1,0,8'h80,32'h0,        4'h0, 1,32'h00,       0};
        vecs[2]  = '{1'b0,1,0,8'hFF,32'h0,        4'h0, 1,32'h00,       0};
        vecs[3]  = '{1'b0,0,1,8'h00,32'h0F,       4'h1, 0,32'h00,       0};
        vecs[4]  = '{1'b0,1,0,8'h00,32'h0,        4'h0, 1,32'h0F,       0};
        vecs[5]  = '{1'b0,0,0,8'h00,32'h0,        4'h0, 0,32'h0F,       0};
        vecs[6]  = '{1'b0,0,1,8'h04,32'h99,       4'h0, 0,32'h0F,       0};
        vecs[7]  = '{1'b0,1,0,8'h04,32'h0,        4'h0, 1,32'h00,       0};
        vecs[8]  = '{1'b0,0,1,8'h03,32'h3C,       4'h1, 0,32'h00,       0};
        vecs[9]  = '{1'b0,1,0,8'h03,32'h0,        4'h0, 1,32'h3C,       0};
        vecs[10] = '{1'b1,0,1,8'h05,32'hAABBCCDD, 4'hF, 0,32'h0,        0};
        vecs[11] = '{1'b1,0,1,8'h05,32'h11223344, 4'h5, 0,32'h0,        0};
        vecs[12] = '{1'b1,1,0,8'h05,32'h0,        4'h0, 1,32'hAA22CC44, 0};
        vecs[13] = '{1'b1,1,1,8'h07,32'hDEADBEEF, 4'h3, 1,32'h0000BEEF, 0};
        vecs[14] = '{1'b1,1,0,8'h07,32'h0,        4'h0, 1,32'h0000BEEF, 0};
        vecs[15] = '{1'b1,0,1,8'hD2,32'h55,       4'hF, 0,32'h0000BEEF, 1};
        vecs[16] = '{1'b1,1,0,8'hD2,32'h0,        4'h0, 1,32'h0,        1};
        vecs[17] = '{1'b1,1,0,8'h52,32'h0,        4'h0, 1,32'h0,        0};
        vecs[18] = '{1'b1,1,0,8'hC7,32'h0,        4'h0, 1,32'h0,        0};
        vecs[19] = '{1'b1,0,1,8'hC8,32'hFFFFFFFF, 4'hF, 0,32'h0,        1};
        vecs[20] = '{1'b1,1,1,8'hC7,32'h12345678, 4'h8, 1,32'h12000000, 0};
        vecs[21] = '{1'b1,0,0,8'h00,32'h0,        4'h0, 0,32'h12000000, 0};
        vecs[22] = '{1'b1,1,0,8'hC8,32'h0,        4'h0, 1,32'h0,        1};
        vecs[23] = '{1'b1,1,0,8'h00,32'h0,        4'h0, 1,32'h0,        0};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("rst_dout_a",  32'(dout_a),  32'h0);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_err_a",   32'(err_a),   32'h0);
        check("rst_busy_a",  32'(busy_a),  32'h1);
        check("rst_dout_b",  dout_b,       32'h0);
        check("rst_busy_b",  32'(busy_b),  32'h1);

        // ---------------- initial clear length ----------------
        reset_n = 1'b1;
        count_busy(cnt_a, cnt_b, saw_v);
        check("init_clear_cycles_a", 32'(cnt_a), 32'd256);
        check("init_clear_cycles_b", 32'(cnt_b), 32'd200);
        check("busy_low_a", 32'(busy_a), 32'h0);

        // ---------------- table-driven accesses (back-to-back) -------------
        for (int i = 0; i < NVEC; i++) begin
            idle_all();
            if (vecs[i].sel_b) begin
                rd_b = vecs[i].rd; wr_b = vecs[i].wr; addr_b = vecs[i].addr;
                din_b = vecs[i].data; be_b = vecs[i].be;
            end else begin
                rd_a = vecs[i].rd; wr_a = vecs[i].wr; addr_a = vecs[i].addr;
                din_a = vecs[i].data[7:0]; be_a = vecs[i].be[0];
            end
            @(negedge clock);
            if (vecs[i].sel_b) begin
                check($sformatf("vec%0d_data_b",  i), dout_b,            vecs[i].exp_data);
                check($sformatf("vec%0d_valid_b", i), 32'(valid_b),      32'(vecs[i].exp_valid));
                check($sformatf("vec%0d_err_b",   i), 32'(err_b),        32'(vecs[i].exp_err));
            end else begin
                check($sformatf("vec%0d_data_a",  i), 32'(dout_a),       vecs[i].exp_data);
                check($sformatf("vec%0d_valid_a", i), 32'(valid_a),      32'(vecs[i].exp_valid));
                check($sformatf("vec%0d_err_a",   i), 32'(err_a),        32'(vecs[i].exp_err));
            end
        end
        idle_all();

        // ---------------- clear request with a simultaneous read -----------
        // addr 3 holds 0x3C and data_out currently shows 0x3C (vec9).
        rd_a = 1; clr_a = 1; addr_a = 8'h03;
        @(negedge clock);
        check("clr_drop_valid", 32'(valid_a), 32'h0);
        check("clr_busy",       32'(busy_a),  32'h1);
        check("clr_dout_hold",  32'(dout_a),  32'h3C);
        // Keep read and clear asserted: both must be ignored while clearing.
        count_busy(cnt_a, cnt_b, saw_v);
        idle_all();
        check("clr_cycles_a",       32'(cnt_a), 32'd256);
        check("clr_no_valid",       32'(saw_v), 32'h0);
        op_a(1, 0, 0, 8'h03, 8'h00, 1'b0);
        check("post_clr_rd3_data",  32'(dout_a),  32'h00);
        check("post_clr_rd3_valid", 32'(valid_a), 32'h1);
        op_a(1, 0, 0, 8'h00, 8'h00, 1'b0);
        check("post_clr_rd0_data",  32'(dout_a),  32'h00);

        // ---------------- reset in the middle of a clear -------------------
        op_a(0, 1, 0, 8'h03, 8'h3C, 1'b1);
        op_a(1, 0, 0, 8'h03, 8'h00, 1'b0);
        check("pre_rst_rd3", 32'(dout_a), 32'h3C);
        op_a(0, 0, 1, 8'h00, 8'h00, 1'b0);
        repeat (20) @(negedge clock);
        check("mid_clear_busy", 32'(busy_a), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_dout_a",  32'(dout_a),  32'h0);
        check("async_rst_valid_a", 32'(valid_a), 32'h0);
        check("async_rst_busy_a",  32'(busy_a),  32'h1);
        check("async_rst_dout_b",  dout_b,       32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        count_busy(cnt_a, cnt_b, saw_v);
        check("restart_cycles_a", 32'(cnt_a), 32'd256);
        check("restart_cycles_b", 32'(cnt_b), 32'd200);
        op_a(1, 0, 0, 8'h03, 8'h00, 1'b0);
        check("restart_rd3_data",  32'(dout_a),  32'h00);
        check("restart_rd3_valid", 32'(valid_a), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
